image_frame_buffer: RTL and testbench
=====================================

# image_frame_buffer

Parametrised, double-buffered (ping-pong) image capture buffer between the byte-serial receive path and the BNN inference core. The write side accepts DATA_W-bit words under a request/ready handshake into one bank. The read side presents the last completed frame on a flat bus to the classifier. Banks swap automatically when a frame completes and the consumer has released the previous one, so reception of frame N+1 overlaps inference on frame N.

## Interface
- IMG_WIDTH, default 30: pixels per row.
- IMG_HEIGHT, default 30: rows per frame.
- DATA_W, default 8: bits per write word.
- NUM_WORDS, derived: ceil(IMG_WIDTH*IMG_HEIGHT/DATA_W), which is 113 at defaults.
- FRAME_BITS, derived: NUM_WORDS*DATA_W, which is 904 at defaults.
- AW, derived: $clog2(NUM_WORDS+1).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear_buffer  in  1  aborts the frame being written.
- data_in  in  DATA_W  write word.
- write_request  in  1  write strobe; the word is accepted when write_request && write_ready.
- write_ready  out  1  the write bank can accept a word.
- write_addr  out  AW  number of words accepted into the current write bank.
- img_consumed  in  1  consumer has finished with img_out.
- img_valid  out  1  img_out holds a complete, unconsumed frame.
- img_out  out  FRAME_BITS  read-bank contents. Word k is at [k*DATA_W +: DATA_W].
- frame_done  out  1  one-cycle pulse on each bank swap.
- frame_count  out  16  number of swaps since reset; wraps modulo 2^16.
- overrun  out  1  sticky flag: a write_request arrived while write_ready=0.

## Operation
- Two banks are held as FRAME_BITS registers. wr_bank selects the bank being written, and the read bank is ~wr_bank.
- Writer FSM:
  - FILL: write_ready=1. Each accepted word is stored at write_addr and write_addr increments.
  - Accepting word NUM_WORDS-1 completes the frame.
    - If the swap condition holds, the banks swap and the FSM stays in FILL.
    - Otherwise the FSM goes to HOLD.
  - HOLD: write_ready=0. The FSM stays in HOLD until the swap condition holds, then swaps and returns to FILL.
- Swap condition: (img_valid==0) || img_consumed.
- Swap action, all at one edge:
  - wr_bank toggles.
  - write_addr becomes 0.
  - The new write bank is zeroed.
  - img_valid becomes 1.
  - frame_done pulses.
  - frame_count increments.
- img_consumed while img_valid=1 and no swap: img_valid becomes 0. img_consumed while img_valid=0 is ignored.
- Pad bits: bits [IMG_WIDTH*IMG_HEIGHT, FRAME_BITS) of the last word are forced to 0 on write. At defaults this is bits 900..903.
- clear_buffer:
  - Zeroes the write bank, sets write_addr to 0 and returns the FSM to FILL. Any pending HOLD frame is discarded.
  - Clears overrun.
  - Does not affect img_valid, img_out, frame_count or the read bank.
- Priority: rst > clear_buffer > swap/write. A write_request in the same cycle as clear_buffer is dropped and does not set overrun.
- Invariant: write_addr <= NUM_WORDS at all times. It equals NUM_WORDS only in HOLD.

## Timing
- Reset values:
  - write_ready=1, write_addr=0.
  - img_valid=0, img_out=0, frame_done=0, frame_count=0, overrun=0.
  - wr_bank=0, both banks zero, FSM in FILL.
- write_ready is combinational from FSM state only: it is 1 in FILL and 0 in HOLD.
- Write latency: a word accepted at edge t is reflected in write_addr after t.
- Immediate swap: if the last word is accepted at edge t and the swap condition holds in that cycle, then after edge t:
  - img_out contains the full frame, including that last word.
  - img_valid=1.
  - frame_done is high for exactly the cycle following t.
  - write_ready stays 1, so the next frame can start at t+1.
- Deferred swap: in HOLD, a swap occurs at the edge where img_consumed is sampled high. write_ready returns to 1 the cycle after that edge.
- Consume and swap in the same cycle: swap wins, so img_valid stays 1 and img_out shows the new frame.
- Back-to-back writes at one word per cycle are sustained. A 113-word frame takes 113 cycles.

## Test plan
- Defaults, reset, then 113 words with value k=0..112 on consecutive cycles:
  - After the 113th word: img_valid=1, frame_done pulses once, frame_count=1.
  - img_out[8k+:8]=k for k<112.
  - Last word 0xFF is stored as 0x0F, because pad bits 900..903 are 0.
- Frame 2 written with img_valid=1 and no img_consumed: write_ready drops after word 113 and img_out is unchanged. Pulse img_consumed: swap on that edge, img_out shows frame 2, write_ready=1 the next cycle.
- img_consumed asserted in the same cycle as the final word of frame 2: immediate swap, img_valid stays 1, frame_count=2.
- 50 words written, then clear_buffer: write_addr=0 and overrun=0. img_out, img_valid and frame_count are unchanged. The next 113 words form a clean frame.
- write_request held during HOLD: no store, overrun=1 and stays set until clear_buffer.
- rst asserted mid-frame with img_valid=1: every output returns to its reset value on the next edge. Rerun with IMG_WIDTH=IMG_HEIGHT=16, DATA_W=32: NUM_WORDS=8 and no pad bits.

Source files
------------

// File: rtl/image_frame_buffer_if.sv
// Write-side and read-side signal bundle for the ping-pong image buffer.
interface image_frame_buffer_if #(
    parameter int IMG_WIDTH  = 30,
    parameter int IMG_HEIGHT = 30,
    parameter int DATA_W     = 8
);
    localparam int NUM_WORDS  = (IMG_WIDTH * IMG_HEIGHT + DATA_W - 1) / DATA_W;
    localparam int FRAME_BITS = NUM_WORDS * DATA_W;
    localparam int AW         = $clog2(NUM_WORDS + 1);

    logic                  clear_buffer;
    logic [DATA_W-1:0]     data_in;
    logic                  write_request;
    logic                  write_ready;
    logic [AW-1:0]         write_addr;
    logic                  img_consumed;
    logic                  img_valid;
    logic [FRAME_BITS-1:0] img_out;
    logic                  frame_done;
    logic [15:0]           frame_count;
    logic                  overrun;

    modport master (
        output clear_buffer, data_in, write_request, img_consumed,
        input  write_ready, write_addr, img_valid, img_out,
        input  frame_done, frame_count, overrun
    );

    modport slave (
        input  clear_buffer, data_in, write_request, img_consumed,
        output write_ready, write_addr, img_valid, img_out,
        output frame_done, frame_count, overrun
    );
endinterface

// File: rtl/image_frame_buffer.sv
// Double-buffered frame capture: one bank fills while the other is held
// for the classifier; banks swap when a frame completes and the reader is free.
module image_frame_buffer #(
    parameter int IMG_WIDTH  = 30,
    parameter int IMG_HEIGHT = 30,
    parameter int DATA_W     = 8
) (
    input logic                 clk,
    input logic                 rst,
    image_frame_buffer_if.slave bus
);
    localparam int NUM_WORDS  = (IMG_WIDTH * IMG_HEIGHT + DATA_W - 1) / DATA_W;
    localparam int FRAME_BITS = NUM_WORDS * DATA_W;
    localparam int AW         = $clog2(NUM_WORDS + 1);
    localparam int IMG_BITS   = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [FRAME_BITS-1:0] KEEP_MASK =
        {FRAME_BITS{1'b1}} >> (FRAME_BITS - IMG_BITS);

    typedef enum logic {FILL, HOLD} state_e;

    state_e                state_q, state_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [FRAME_BITS-1:0] bank_q [2];
    logic [FRAME_BITS-1:0] bank_d [2];
    logic [AW-1:0]         addr_q, addr_d;
    logic                  img_valid_q, img_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic                  overrun_q, overrun_d;
    logic                  swap_ok, swap, accept, last;

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        bank_d        = bank_q;
        addr_d        = addr_q;
        img_valid_d   = img_valid_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        swap          = 1'b0;
        swap_ok       = !img_valid_q || bus.img_consumed;
        accept        = (state_q == FILL) && bus.write_request;
        last          = (addr_q == AW'(NUM_WORDS - 1));

        if (bus.clear_buffer) begin
            bank_d[wr_bank_q] = '0;
            addr_d            = '0;
            state_d           = FILL;
            overrun_d         = 1'b0;
        end else begin
            if (accept) begin
                bank_d[wr_bank_q][int'(addr_q)*DATA_W +: DATA_W] = bus.data_in;
                // Pad bits past the last pixel always read back as zero
                bank_d[wr_bank_q] = bank_d[wr_bank_q] & KEEP_MASK;
                addr_d = addr_q + AW'(1);
                if (last) begin
                    if (swap_ok) swap = 1'b1;
                    else state_d = HOLD;
                end
            end
            if (state_q == HOLD) begin
                if (bus.write_request) overrun_d = 1'b1;
                if (swap_ok) swap = 1'b1;
            end
            if (swap) begin
                wr_bank_d          = !wr_bank_q;
                bank_d[!wr_bank_q] = '0;
                addr_d             = '0;
                img_valid_d        = 1'b1;
                frame_done_d       = 1'b1;
                frame_count_d      = frame_count_q + 16'd1;
                state_d            = FILL;
            end
        end

        // A swap re-arms img_valid; otherwise a consume releases the frame
        if (!swap && bus.img_consumed) img_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            wr_bank_q     <= 1'b0;
            bank_q[0]     <= '0;
            bank_q[1]     <= '0;
            addr_q        <= '0;
            img_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            addr_q        <= addr_d;
            img_valid_q   <= img_valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.write_ready = (state_q == FILL);
    assign bus.write_addr  = addr_q;
    assign bus.img_valid   = img_valid_q;
    assign bus.img_out     = bank_q[!wr_bank_q];
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_image_frame_buffer.sv
// Randomised scoreboard bench for image_frame_buffer at default size,
// plus a short directed run of a 16x16 / 32-bit-word configuration.
module tb_image_frame_buffer;
    localparam int W    = 30;
    localparam int H    = 30;
    localparam int DW   = 8;
    localparam int NW   = 113;
    localparam int FB   = 904;
    localparam int IMGB = 900;
    localparam int DW2  = 32;
    localparam int NW2  = 8;
    localparam int FB2  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst2;

    image_frame_buffer_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) bus ();
    image_frame_buffer_if #(.IMG_WIDTH(16), .IMG_HEIGHT(16), .DATA_W(DW2)) bus2 ();

    image_frame_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    image_frame_buffer #(.IMG_WIDTH(16), .IMG_HEIGHT(16), .DATA_W(DW2)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [FB-1:0] frame;
        int            count;
    } exp_t;
    exp_t sb[$];

    // Reference model: accepted words of the open frame, plus reader state
    logic [DW-1:0] m_q[$];
    bit            m_hold, m_valid, m_ovr;
    int            m_count;
    logic [FB-1:0] m_rd;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(string nm, logic [FB-1:0] act, logic [FB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < FB / DW; i++) begin
                if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
                    $display("FAIL %s: byte %0d got %0h expected %0h",
                             nm, i, act[i*DW +: DW], exp[i*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [FB-1:0] build();
        logic [FB-1:0] f;
        f = '0;
        foreach (m_q[i]) f[i*DW +: DW] = m_q[i];
        for (int b = IMGB; b < FB; b++) f[b] = 1'b0;
        return f;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hold  = 0;
        m_valid = 0;
        m_ovr   = 0;
        m_count = 0;
        m_rd    = '0;
    endtask

    task automatic model_step(bit req, logic [DW-1:0] d, bit cons, bit clr);
        bit ok, sw;
        ok = !m_valid || cons;
        sw = 0;
        if (clr) begin
            m_q.delete();
            m_hold = 0;
            m_ovr  = 0;
        end else if (!m_hold) begin
            if (req) begin
                m_q.push_back(d);
                if (m_q.size() == NW) begin
                    if (ok) sw = 1;
                    else m_hold = 1;
                end
            end
        end else begin
            if (req) m_ovr = 1;
            if (ok) sw = 1;
        end
        if (sw) begin
            m_rd = build();
            m_q.delete();
            m_hold  = 0;
            m_valid = 1;
            m_count++;
            sb.push_back('{m_rd, m_count});
        end else if (cons) begin
            m_valid = 0;
        end
    endtask

    task automatic check_state();
        chk("write_ready", 64'(bus.write_ready), 64'(!m_hold));
        chk("write_addr", 64'(bus.write_addr), 64'(m_q.size()));
        chk("img_valid", 64'(bus.img_valid), 64'(m_valid));
        chk("overrun", 64'(bus.overrun), 64'(m_ovr));
        chk("frame_count", 64'(bus.frame_count), 64'(m_count & 16'hFFFF));
        chk_frame("img_out", bus.img_out, m_rd);
    endtask

    task automatic cyc(bit req, logic [DW-1:0] d, bit cons, bit clr);
        @(negedge clk);
        rst               = 1'b0;
        bus.write_request = req;
        bus.data_in       = d;
        bus.img_consumed  = cons;
        bus.clear_buffer  = clr;
        model_step(req, d, cons, clr);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst               = 1'b1;
        bus.write_request = 1'b0;
        bus.img_consumed  = 1'b0;
        bus.clear_buffer  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_state();
        chk("frame_done_rst", 64'(bus.frame_done), 64'd0);
    endtask

    task automatic write_words(int n, bit last_cons);
        for (int i = 0; i < n; i++)
            cyc(1'b1, DW'($urandom), (i == n - 1) && last_cons, 1'b0);
    endtask

    // Monitor: each frame_done pulse must match the oldest predicted swap
    always begin
        @(posedge clk);
        #2;
        if (bus.frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected_frame_done: got 1 expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_frame("sb_frame", bus.img_out, e.frame);
                chk("sb_count", 64'(bus.frame_count), 64'(e.count & 16'hFFFF));
                chk("sb_valid", 64'(bus.img_valid), 64'd1);
            end
        end
    end

    logic [DW2-1:0] w2 [NW2];
    logic [FB-1:0]  e2;

    initial begin
        rst                = 1'b1;
        rst2               = 1'b1;
        bus.write_request  = 1'b0;
        bus.data_in        = '0;
        bus.img_consumed   = 1'b0;
        bus.clear_buffer   = 1'b0;
        bus2.write_request = 1'b0;
        bus2.data_in       = '0;
        bus2.img_consumed  = 1'b0;
        bus2.clear_buffer  = 1'b0;
        model_reset();

        do_reset();

        // Frame 1: ramp with an all-ones last word to expose the pad bits
        for (int k = 0; k < NW; k++)
            cyc(1'b1, (k == NW - 1) ? 8'hFF : DW'(k), 1'b0, 1'b0);
        chk("f1_word5", 64'(bus.img_out[47:40]), 64'd5);
        chk("f1_word111", 64'(bus.img_out[895:888]), 64'd111);
        chk("f1_pad_word", 64'(bus.img_out[903:896]), 64'h0F);

        // Frame 2 stalls in HOLD, overrun on held requests, consume releases
        write_words(NW, 1'b0);
        chk("f2_hold_ready", 64'(bus.write_ready), 64'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Frame 3: consume lands with the final word
        write_words(NW, 1'b1);

        // Partial frame aborted, then a clean frame that must wait in HOLD
        write_words(50, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        write_words(NW, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b1);

        // Reset in the middle of a frame while a frame is still valid
        write_words(20, 1'b0);
        chk("pre_rst_valid", 64'(bus.img_valid), 64'd1);
        do_reset();

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 9) < 7, DW'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Wide-word configuration: 8 words, no pad bits
        @(negedge clk);
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        chk("c2_rst_addr", 64'(bus2.write_addr), 64'd0);
        chk("c2_rst_valid", 64'(bus2.img_valid), 64'd0);
        chk("c2_rst_ready", 64'(bus2.write_ready), 64'd1);
        e2 = '0;
        for (int i = 0; i < NW2; i++) begin
            w2[i] = $urandom;
            e2[i*DW2 +: DW2] = w2[i];
            @(negedge clk);
            rst2               = 1'b0;
            bus2.write_request = 1'b1;
            bus2.data_in       = w2[i];
            @(posedge clk);
            #1;
            if (i < NW2 - 1)
                chk("c2_addr", 64'(bus2.write_addr), 64'(i + 1));
        end
        @(negedge clk);
        bus2.write_request = 1'b0;
        chk("c2_frame_done", 64'(bus2.frame_done), 64'd1);
        chk("c2_valid", 64'(bus2.img_valid), 64'd1);
        chk("c2_count", 64'(bus2.frame_count), 64'd1);
        chk("c2_addr_wrap", 64'(bus2.write_addr), 64'd0);
        chk_frame("c2_img_out", FB'(bus2.img_out), e2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
